// File: rtl/game_pkg.sv
// Shared encodings for the brick-breaker game controller: FSM state codes,
// sound request codes and score limits.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_e;

    localparam logic [2:0] SND_SILENT = 3'b000;
    localparam logic [2:0] SND_MISS   = 3'b100;
    localparam logic [2:0] SND_WIN    = 3'b101;
    localparam logic [2:0] SND_OVER   = 3'b110;

    localparam logic [13:0] SCORE_MAX = 14'd9999;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with one registered stage; the pulse is
// combinational from the live input against the previous sample.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic pe_o
);

    logic din_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_i;
        end
    end

    assign pe_o = din_i & ~din_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencing FSM: serve delay, miss/lives bookkeeping, saturating score,
// brick-completion win detection and a frame-timed sound request latch.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 7,
    parameter int NUM_BLOCKS   = 25,
    parameter int SOUND_FRAMES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        frame_tick,
    input  logic [9:0]  ball_y,
    input  logic        erase_enable,
    input  logic [1:0]  active_data,
    output logic        ball_reset,
    output logic        ball_step,
    output logic [1:0]  lives,
    output logic [13:0] score,
    output logic [2:0]  state,
    output logic [2:0]  sound_code
);

    localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);
    localparam int HOLD_W  = $clog2(SOUND_FRAMES + 1);

    state_e              state_q, state_d;
    logic [1:0]          lives_q, lives_d;
    logic [13:0]         score_q, score_d;
    logic [5:0]          bricks_q, bricks_d;
    logic [SERVE_W-1:0]  serve_q, serve_d;
    logic [2:0]          snd_q, snd_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic start_pe;
    logic in_play;
    logic play_hit;
    logic hit_full;
    logic [5:0] bricks_inc;
    logic last_brick;
    logic ball_missed;
    logic serve_done;
    logic entering;

    edge_detect u_start_edge (
        .clk   (clk),
        .reset (reset),
        .din_i (start_btn),
        .pe_o  (start_pe)
    );

    assign in_play     = (state_q == ST_PLAY);
    assign play_hit    = in_play & erase_enable;
    assign hit_full    = play_hit & (active_data == 2'd3);
    assign bricks_inc  = bricks_q + {5'd0, hit_full};
    assign last_brick  = hit_full & (bricks_inc == 6'(NUM_BLOCKS));
    assign ball_missed = ball_y > 10'(SCREEN_H - BALL_SIZE);
    assign serve_done  = frame_tick & (serve_q == SERVE_W'(SERVE_FRAMES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a finishing brick outranks a simultaneous miss
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_pe) state_d = ST_SERVE;
            ST_SERVE: if (serve_done) state_d = ST_PLAY;
            ST_PLAY: begin
                if (last_brick)       state_d = ST_WIN;
                else if (ball_missed) state_d = ST_MISS;
            end
            ST_MISS:  state_d = (lives_q <= 2'd1) ? ST_OVER : ST_SERVE;
            ST_OVER,
            ST_WIN:   if (start_pe) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ball_reset = reset | ~in_play;
        ball_step  = ~reset & in_play & frame_tick;
        state      = state_q;
        lives      = lives_q;
        score      = score_q;
        sound_code = snd_q;
    end

    assign entering = (state_d != state_q);

    always_comb begin
        lives_d  = lives_q;
        score_d  = score_q;
        bricks_d = bricks_q;
        serve_d  = '0;
        snd_d    = snd_q;
        hold_d   = hold_q;

        if (state_q == ST_IDLE && start_pe) begin
            lives_d = 2'(LIVES_INIT);
            score_d = '0;
        end

        if (state_q == ST_MISS) begin
            lives_d = (lives_q <= 2'd1) ? 2'd0 : lives_q - 2'd1;
        end

        if (state_q == ST_SERVE) begin
            serve_d = frame_tick ? serve_q + SERVE_W'(1) : serve_q;
        end

        if (play_hit) begin
            score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : score_q + 14'd1;
        end

        // The datapath rebuilds its wall whenever it is held in reset
        bricks_d = in_play ? bricks_inc : 6'd0;

        if (entering && state_d == ST_MISS) begin
            snd_d  = SND_MISS;
            hold_d = HOLD_W'(SOUND_FRAMES);
        end else if (entering && state_d == ST_WIN) begin
            snd_d  = SND_WIN;
            hold_d = HOLD_W'(SOUND_FRAMES);
        end else if (entering && state_d == ST_OVER) begin
            snd_d  = SND_OVER;
            hold_d = HOLD_W'(SOUND_FRAMES);
        end else if (play_hit) begin
            snd_d  = {1'b0, active_data};
            hold_d = HOLD_W'(SOUND_FRAMES);
        end else if (frame_tick && snd_q != SND_SILENT) begin
            if (hold_q <= HOLD_W'(1)) begin
                snd_d  = SND_SILENT;
                hold_d = '0;
            end else begin
                hold_d = hold_q - HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lives_q  <= '0;
            score_q  <= '0;
            bricks_q <= '0;
            serve_q  <= '0;
            snd_q    <= SND_SILENT;
            hold_q   <= '0;
        end else begin
            lives_q  <= lives_d;
            score_q  <= score_d;
            bricks_q <= bricks_d;
            serve_q  <= serve_d;
            snd_q    <= snd_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: expectations are queued as stimulus is
// applied and popped against the DUT outputs one step later.
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_btn;
    logic        frame_tick;
    logic [9:0]  ball_y;
    logic        erase_enable;
    logic [1:0]  active_data;
    logic        ball_reset;
    logic        ball_step;
    logic [1:0]  lives;
    logic [13:0] score;
    logic [2:0]  state;
    logic [2:0]  sound_code;

    always #5 clk = ~clk;

    game_ctrl #(
        .LIVES_INIT   (3),
        .SERVE_FRAMES (60),
        .SCREEN_H     (480),
        .BALL_SIZE    (7),
        .NUM_BLOCKS   (25),
        .SOUND_FRAMES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_btn    (start_btn),
        .frame_tick   (frame_tick),
        .ball_y       (ball_y),
        .erase_enable (erase_enable),
        .active_data  (active_data),
        .ball_reset   (ball_reset),
        .ball_step    (ball_step),
        .lives        (lives),
        .score        (score),
        .state        (state),
        .sound_code   (sound_code)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
            $display("check %s observed=%0d expected=%0d", e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    task automatic press();
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        tick();
    endtask

    task automatic serve_to_play();
        repeat (60) frame();
        expect_val("serve_to_play_state", 2);
        check(32'(state));
    endtask

    task automatic hit(input logic [1:0] ad);
        erase_enable = 1'b1;
        active_data  = ad;
        tick();
        erase_enable = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; start_btn = 1'b0; frame_tick = 1'b0;
        ball_y = 10'd0; erase_enable = 1'b0; active_data = 2'd0;
        repeat (3) tick();

        // Reset state, with frame_tick high to prove ball_step stays low
        frame_tick = 1'b1;
        #1;
        expect_val("rst_state", 0);      check(32'(state));
        expect_val("rst_lives", 0);      check(32'(lives));
        expect_val("rst_score", 0);      check(32'(score));
        expect_val("rst_sound", 0);      check(32'(sound_code));
        expect_val("rst_ball_reset", 1); check(32'(ball_reset));
        expect_val("rst_ball_step", 0);  check(32'(ball_step));
        frame_tick = 1'b0;
        reset = 1'b0;
        tick();

        press();
        expect_val("start_state", 1); check(32'(state));
        expect_val("start_lives", 3); check(32'(lives));
        expect_val("start_ball_reset", 1); check(32'(ball_reset));

        repeat (59) frame();
        expect_val("serve_59_state", 1); check(32'(state));
        frame();
        expect_val("serve_60_state", 2); check(32'(state));

        frame_tick = 1'b1;
        #1;
        expect_val("play_step_hi", 1);   check(32'(ball_step));
        expect_val("play_ball_reset", 0); check(32'(ball_reset));
        tick();
        frame_tick = 1'b0;
        #1;
        expect_val("play_step_lo", 0);   check(32'(ball_step));

        // Three misses exhaust the lives
        for (int m = 0; m < 3; m++) begin
            ball_y = 10'd474;
            tick();
            ball_y = 10'd0;
            expect_val("miss_state", 3); check(32'(state));
            expect_val("miss_sound", 4); check(32'(sound_code));
            tick();
            if (m < 2) begin
                expect_val("after_miss_state", 1); check(32'(state));
                expect_val("after_miss_lives", 32'(2 - m)); check(32'(lives));
                serve_to_play();
            end else begin
                expect_val("over_state", 4); check(32'(state));
                expect_val("over_lives", 0); check(32'(lives));
                expect_val("over_sound", 6); check(32'(sound_code));
            end
        end

        // OVER -> IDLE -> new game
        start_btn = 1'b1;
        tick();
        start_btn = 1'b0;
        expect_val("over_to_idle", 0); check(32'(state));
        tick();
        press();
        expect_val("game2_state", 1); check(32'(state));
        expect_val("game2_lives", 3); check(32'(lives));

        hit(2'd3);
        expect_val("serve_erase_ignored", 0); check(32'(score));
        serve_to_play();

        press();
        expect_val("play_start_ignored", 2); check(32'(state));

        // 25 bricks of three hits each
        for (int b = 0; b < 25; b++) begin
            for (int h = 1; h <= 3; h++) begin
                hit(2'(h));
                if (b == 24 && h == 2) begin
                    expect_val("hit74_state", 2); check(32'(state));
                    expect_val("hit74_score", 74); check(32'(score));
                    expect_val("hit74_sound", 2); check(32'(sound_code));
                end
            end
        end
        expect_val("win_state", 5);  check(32'(state));
        expect_val("win_score", 75); check(32'(score));
        expect_val("win_sound", 5);  check(32'(sound_code));
        repeat (7) frame();
        expect_val("win_sound_7f", 5); check(32'(sound_code));
        frame();
        expect_val("win_sound_8f", 0); check(32'(sound_code));
        expect_val("win_score_held", 75); check(32'(score));

        // Last brick coincides with a miss
        press();
        expect_val("win_to_idle", 0); check(32'(state));
        press();
        expect_val("game3_score_clear", 0); check(32'(score));
        serve_to_play();
        repeat (24) hit(2'd3);
        expect_val("pre_last_state", 2); check(32'(state));
        erase_enable = 1'b1;
        active_data  = 2'd3;
        ball_y       = 10'd479;
        tick();
        erase_enable = 1'b0;
        ball_y       = 10'd0;
        expect_val("tie_state", 5);  check(32'(state));
        expect_val("tie_lives", 3);  check(32'(lives));
        expect_val("tie_score", 25); check(32'(score));
        expect_val("tie_sound", 5);  check(32'(sound_code));

        // Score saturation
        press();
        press();
        serve_to_play();
        erase_enable = 1'b1;
        active_data  = 2'd1;
        repeat (9998) tick();
        expect_val("score_9998", 9998); check(32'(score));
        repeat (3) tick();
        erase_enable = 1'b0;
        expect_val("score_sat", 9999);  check(32'(score));
        expect_val("sat_state", 2);     check(32'(state));
        expect_val("sat_sound", 1);     check(32'(sound_code));

        // Reset mid-PLAY with a sound pending
        reset        = 1'b1;
        erase_enable = 1'b1;
        active_data  = 2'd3;
        tick();
        expect_val("midrst_state", 0);      check(32'(state));
        expect_val("midrst_sound", 0);      check(32'(sound_code));
        expect_val("midrst_ball_reset", 1); check(32'(ball_reset));
        expect_val("midrst_score", 0);      check(32'(score));
        expect_val("midrst_lives", 0);      check(32'(lives));
        reset        = 1'b0;
        erase_enable = 1'b0;
        tick();
        expect_val("post_rst_state", 0); check(32'(state));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameters SHALL be: LIVES_INIT, default 3, lives granted per game; SERVE_FRAMES, default 60, frame ticks held in SERVE; SCREEN_H, default 480, screen height in pixels; BALL_SIZE, default 7, ball size in pixels; NUM_BLOCKS, default 25, brick count; SOUND_FRAMES, default 8, frame ticks a sound code is held.
REQ-002 Ports SHALL be, in order:
  clk  in  1  system clock; one clock, reset is synchronous and active-high;
  reset  in  1  synchronous active-high reset;
  start_btn  in  1  raw start button, already debounced;
  frame_tick  in  1  one-cycle pulse per video frame;
  ball_y  in  10  ball y position from the ball datapath;
  erase_enable  in  1  brick-hit strobe from the ball datapath;
  active_data  in  2  hit count of the struck brick, 1..3, valid with erase_enable;
  ball_reset  out  1  holds the ball datapath in reset;
  ball_step  out  1  one-cycle move enable for the ball datapath;
  lives  out  2  remaining lives;
  score  out  14  binary score, range 0..9999;
  state  out  3  current FSM state code;
  sound_code  out  3  sound request, 0 means silent.

Function
REQ-003 FSM states SHALL be IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5.
REQ-004 start_btn SHALL be rising-edge detected with one registered stage, giving start_pe.
REQ-005 IDLE: ball_reset=1. On start_pe, the FSM SHALL go to SERVE, set lives=LIVES_INIT and clear score.
REQ-006 SERVE: ball_reset=1. The serve counter SHALL clear on entry and increment on each frame_tick. When the count reaches SERVE_FRAMES-1 with a frame_tick, the FSM SHALL go to PLAY.
REQ-007 PLAY: ball_reset=0 and ball_step=frame_tick, combinational, with no added latency. ball_step SHALL be 0 in every other state.
REQ-008 PLAY: ball_y > SCREEN_H-BALL_SIZE (unsigned 10-bit compare) SHALL cause a transition to MISS on the next edge.
REQ-009 PLAY: on erase_enable, score SHALL add 1, saturating at 9999. If active_data==3, bricks_done SHALL also increment. Both updates SHALL be registered.
REQ-010 PLAY: when bricks_done reaches NUM_BLOCKS (counting the current increment), the FSM SHALL go to WIN. If this coincides with a miss in the same cycle, WIN SHALL take priority.
REQ-011 MISS lasts one cycle. If lives==1, lives SHALL go to 0 and the FSM to OVER. Otherwise lives SHALL decrement and the FSM go to SERVE.
REQ-012 OVER and WIN: ball_reset=1 and score is held. start_pe SHALL go to IDLE.
REQ-013 bricks_done (6-bit) SHALL clear whenever ball_reset=1, because the datapath restores its bricks on reset.
REQ-014 erase_enable outside PLAY SHALL be ignored.
REQ-015 sound_code SHALL latch on an event: 3'b100 on MISS entry, 3'b101 on WIN entry, 3'b110 on OVER entry, {1'b0,active_data} on a counted brick hit. It SHALL then be held for SOUND_FRAMES frame_ticks and return to 0. A new event SHALL overwrite the code and restart the hold.
REQ-016 start_pe in SERVE, PLAY or MISS SHALL be ignored.

Reset
REQ-017 While reset=1, at any clk edge and in any state, the block SHALL force: state=IDLE, lives=0, score=0, bricks_done=0, serve counter=0, sound_code=0, sound hold counter=0, edge-detect register=0.
REQ-018 During and after reset, ball_reset SHALL be 1 and ball_step 0 until the FSM reaches PLAY.
REQ-019 Reset asserted mid-PLAY SHALL take effect on the next clk edge with no partial updates.

Structure
REQ-020 State encodings and sound codes SHALL live in the shared package game_pkg.
REQ-021 The score saturating adder and sound hold timer SHALL stay inline. The start edge detector SHALL be a sub-module, edge_detect.
REQ-022 All registers SHALL update on posedge clk only. No gated clocks are permitted; ball_step is an enable, not a clock.

Verification
REQ-023 reset 3 cycles, then start_btn pulse -> state IDLE->SERVE, lives=3; after 60 frame_ticks -> PLAY; ball_step mirrors frame_tick.
REQ-024 In PLAY, force ball_y=474 -> MISS for 1 cycle, then SERVE with lives=2; repeat twice -> lives=0, state=OVER, sound_code=3'b110.
REQ-025 In PLAY, 75 erase_enable pulses (active_data 1,2,3 per brick, 25 bricks) -> score=75, WIN on the 75th pulse, sound_code=3'b101 held for 8 frame_ticks then 0.
REQ-026 Last-brick erase_enable in the same cycle as ball_y=479 -> WIN, lives unchanged.
REQ-027 Preload score=9998, apply 3 hits -> score=9999 held.
REQ-028 reset asserted mid-PLAY with sound active -> next cycle state=IDLE, sound_code=0, ball_reset=1, score=0.
